// File: rtl/pll_clk_monitor.sv
// pll_clk_monitor
// Measures the pll_clk frequency by counting pll_clk cycles across a
// programmable number of ext_clk periods. Each result is checked against a
// [min_count, max_count] window. pll_locked asserts after LOCK_WINS
// consecutive in-range results. All logic runs in the pll_clk domain.

module pll_clk_monitor #(
  parameter int WINDOW_W  = 8,
  parameter int CNT_W     = 16,
  parameter int LOCK_WINS = 4
) (
  input  logic                pll_clk,
  input  logic                reset_n_async,
  input  logic                ext_clk,
  input  logic                enable,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window,
  input  logic [CNT_W-1:0]    min_count,
  input  logic [CNT_W-1:0]    max_count,
  output logic [CNT_W-1:0]    count,
  output logic                count_valid,
  output logic                in_range,
  output logic                pll_locked,
  output logic                overflow,
  output logic                timeout,
  output logic                busy
);

  localparam int GOOD_W = $clog2(LOCK_WINS + 1);

  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [WINDOW_W-1:0] WIN_ONE   = WINDOW_W'(1);
  localparam logic [GOOD_W-1:0]   GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]   GOOD_FULL = GOOD_W'(LOCK_WINS);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  state_t state, state_next;

  logic ext_s1, ext_s2, ext_s3;
  logic ext_rise;
  logic enable_q;
  logic enable_drop;

  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc;
  logic [WINDOW_W-1:0] edges, edges_next, edges_inc, window_eff;
  logic [GOOD_W-1:0]   good, good_next;

  logic [CNT_W-1:0] count_next;
  logic             count_valid_next;
  logic             in_range_next;
  logic             pll_locked_next;
  logic             overflow_next;
  logic             timeout_next;

  logic             result_load;
  logic [CNT_W-1:0] result_count;
  logic             result_ovf;
  logic             result_tmo;
  logic             result_in_range;

  // Two-flop synchroniser for ext_clk plus one history flop for rise detection
  always_ff @(posedge pll_clk or negedge reset_n_async) begin
    if (!reset_n_async) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      ext_s3   <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      ext_s1   <= ext_clk;
      ext_s2   <= ext_s1;
      ext_s3   <= ext_s2;
      enable_q <= enable;
    end
  end

  assign ext_rise    = ext_s2 & ~ext_s3;
  assign enable_drop = enable_q & ~enable & ~start;
  assign cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign edges_inc   = edges + WIN_ONE;
  assign window_eff  = (window == '0) ? WIN_ONE : window;
  assign busy        = (state != IDLE);

  // Next-state, counter and result computation for the measurement sequencer
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    edges_next       = edges;
    good_next        = good;
    count_next       = count;
    count_valid_next = 1'b0;
    in_range_next    = in_range;
    pll_locked_next  = pll_locked;
    overflow_next    = overflow;
    timeout_next     = timeout;
    result_load      = 1'b0;
    result_count     = '0;
    result_ovf       = 1'b0;
    result_tmo       = 1'b0;

    case (state)
      IDLE: begin
        if (start || enable) begin
          state_next = ARM;
          cnt_next   = '0;
        end
      end
      ARM: begin
        if (enable_drop) begin
          state_next      = IDLE;
          good_next       = '0;
          pll_locked_next = 1'b0;
        end else if (ext_rise) begin
          state_next = MEASURE;
          cnt_next   = '0;
          edges_next = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_next   = DONE;
          result_load  = 1'b1;
          result_count = '0;
          result_tmo   = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      MEASURE: begin
        if (enable_drop) begin
          state_next      = IDLE;
          good_next       = '0;
          pll_locked_next = 1'b0;
        end else begin
          cnt_next = cnt_inc;
          if (ext_rise) begin
            if (edges_inc == window_eff) begin
              state_next   = DONE;
              result_load  = 1'b1;
              result_count = cnt_inc;
              result_ovf   = (cnt_inc == CNT_MAX);
            end else begin
              edges_next = edges_inc;
            end
          end
        end
      end
      DONE: begin
        state_next = enable ? ARM : IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    result_in_range = ~result_ovf & ~result_tmo &
                      (result_count >= min_count) & (result_count <= max_count);

    if (result_load) begin
      count_valid_next = 1'b1;
      count_next       = result_count;
      overflow_next    = result_ovf;
      timeout_next     = result_tmo;
      in_range_next    = result_in_range;
      if (result_in_range) begin
        good_next = (good == GOOD_FULL) ? good : good + GOOD_ONE;
      end else begin
        good_next = '0;
      end
      pll_locked_next = (good_next == GOOD_FULL);
    end
  end

  // State, counters and registered result outputs
  always_ff @(posedge pll_clk or negedge reset_n_async) begin
    if (!reset_n_async) begin
      state       <= IDLE;
      cnt         <= '0;
      edges       <= '0;
      good        <= '0;
      count       <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      pll_locked  <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      edges       <= edges_next;
      good        <= good_next;
      count       <= count_next;
      count_valid <= count_valid_next;
      in_range    <= in_range_next;
      pll_locked  <= pll_locked_next;
      overflow    <= overflow_next;
      timeout     <= timeout_next;
    end
  end

endmodule

// File: tb/tb_pll_clk_monitor.sv
// tb_pll_clk_monitor
// Drives ext_clk as an exact multiple of pll_clk and checks every cycle
// against an arithmetic model of the expected measurement results, plus
// directed literal expectations for reset, lock, timeout and range edges.

module tb_pll_clk_monitor;

  // Narrower counter so saturation and timeout windows stay a few thousand cycles long
  localparam int WINDOW_W  = 8;
  localparam int CNT_W     = 12;
  localparam int LOCK_WINS = 4;
  localparam int CNT_MAXV  = (1 << CNT_W) - 1;

  logic                pll_clk       = 1'b0;
  logic                reset_n_async = 1'b0;
  logic                ext_clk       = 1'b0;
  logic                enable        = 1'b0;
  logic                start         = 1'b0;
  logic [WINDOW_W-1:0] window;
  logic [CNT_W-1:0]    min_count;
  logic [CNT_W-1:0]    max_count;
  logic [CNT_W-1:0]    count;
  logic                count_valid;
  logic                in_range;
  logic                pll_locked;
  logic                overflow;
  logic                timeout;
  logic                busy;

  int     n_compared   = 0;
  int     n_mismatched = 0;
  int     ext_period   = 0;
  int     ext_phase    = 0;
  int     valid_seen   = 0;
  longint cyc_count    = 0;
  longint valid_cyc    = 0;
  longint start_cyc    = 0;

  int m_count = 0;
  int m_good  = 0;
  bit m_inr   = 1'b0;
  bit m_ovf   = 1'b0;
  bit m_tmo   = 1'b0;
  bit m_lock  = 1'b0;

  typedef struct {
    int period;
    int win;
    int mn;
    int mx;
    int exp_count;
    bit exp_inr;
    bit exp_ovf;
  } vec_t;

  vec_t vecs [8] = '{
    '{10,   0,  0, 4095,   10, 1'b1, 1'b0},
    '{20, 255,  0, 4095, 4095, 1'b0, 1'b1},
    '{21, 195,  0, 4095, 4095, 1'b0, 1'b1},
    '{46,  89,  0, 4095, 4094, 1'b1, 1'b0},
    '{10,   4, 50,   40,   40, 1'b0, 1'b0},
    '{10,   4, 40,   40,   40, 1'b1, 1'b0},
    '{10,   4, 41, 4095,   40, 1'b0, 1'b0},
    '{10,   4,  0,   39,   40, 1'b0, 1'b0}
  };

  pll_clk_monitor #(
    .WINDOW_W (WINDOW_W),
    .CNT_W    (CNT_W),
    .LOCK_WINS(LOCK_WINS)
  ) dut (
    .pll_clk      (pll_clk),
    .reset_n_async(reset_n_async),
    .ext_clk      (ext_clk),
    .enable       (enable),
    .start        (start),
    .window       (window),
    .min_count    (min_count),
    .max_count    (max_count),
    .count        (count),
    .count_valid  (count_valid),
    .in_range     (in_range),
    .pll_locked   (pll_locked),
    .overflow     (overflow),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 pll_clk = ~pll_clk;

  always @(posedge pll_clk) cyc_count <= cyc_count + 1;

  // Reference clock: rises exactly every ext_period pll_clk cycles, stuck low when 0
  always @(negedge pll_clk) begin
    if (ext_period == 0) begin
      ext_phase = 0;
      ext_clk   = 1'b0;
    end else begin
      ext_phase = (ext_phase + 1 >= ext_period) ? 0 : ext_phase + 1;
      ext_clk   = (ext_phase < ext_period / 2);
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Expected result of one finished window from period, window and limits
  task automatic modelUpdate();
    int     w;
    longint prod;
    w = (window == 0) ? 1 : int'(window);
    if (ext_period == 0) begin
      m_count = 0;
      m_tmo   = 1'b1;
      m_ovf   = 1'b0;
    end else begin
      prod  = longint'(w) * longint'(ext_period);
      m_tmo = 1'b0;
      if (prod >= CNT_MAXV) begin
        m_count = CNT_MAXV;
        m_ovf   = 1'b1;
      end else begin
        m_count = int'(prod);
        m_ovf   = 1'b0;
      end
    end
    m_inr  = !m_ovf && !m_tmo && (m_count >= int'(min_count)) && (m_count <= int'(max_count));
    m_good = m_inr ? ((m_good < LOCK_WINS) ? m_good + 1 : LOCK_WINS) : 0;
    m_lock = (m_good == LOCK_WINS);
  endtask

  task automatic modelClear();
    m_count = 0;
    m_good  = 0;
    m_inr   = 1'b0;
    m_ovf   = 1'b0;
    m_tmo   = 1'b0;
    m_lock  = 1'b0;
  endtask

  // Per-cycle comparison of the registered results against the model
  always @(negedge pll_clk) begin
    if (reset_n_async) begin
      if (count_valid === 1'b1) begin
        modelUpdate();
        valid_seen++;
        valid_cyc = cyc_count;
      end
      checkOutput("cmp_count",    count,      m_count);
      checkOutput("cmp_in_range", in_range,   m_inr);
      checkOutput("cmp_overflow", overflow,   m_ovf);
      checkOutput("cmp_timeout",  timeout,    m_tmo);
      checkOutput("cmp_locked",   pll_locked, m_lock);
    end
  end

  task automatic applyStimulus(input int period, input int win, input int mn, input int mx);
    ext_period = period;
    window     = WINDOW_W'(win);
    min_count  = CNT_W'(mn);
    max_count  = CNT_W'(mx);
    repeat (6) @(posedge pll_clk);
  endtask

  task automatic pulseStart();
    @(posedge pll_clk);
    #1 start = 1'b1;
    @(posedge pll_clk);
    #1;
    start_cyc = cyc_count;
    start     = 1'b0;
  endtask

  task automatic waitValid(input int target, input int limit, input string tag);
    int cyc;
    cyc = 0;
    while (valid_seen < target && cyc < limit) begin
      @(posedge pll_clk);
      cyc++;
    end
    #1;
    checkOutput(tag, valid_seen, target);
  endtask

  task automatic applyReset();
    reset_n_async = 1'b0;
    enable        = 1'b0;
    start         = 1'b0;
    modelClear();
    repeat (3) @(posedge pll_clk);
    #2 reset_n_async = 1'b1;
    repeat (4) @(posedge pll_clk);
  endtask

  initial begin
    int base;
    window     = 8'd4;
    min_count  = 12'd38;
    max_count  = 12'd42;
    ext_period = 10;

    // Reset state
    repeat (3) @(posedge pll_clk);
    #1;
    checkOutput("rst_count",       count,       0);
    checkOutput("rst_count_valid", count_valid, 0);
    checkOutput("rst_in_range",    in_range,    0);
    checkOutput("rst_locked",      pll_locked,  0);
    checkOutput("rst_overflow",    overflow,    0);
    checkOutput("rst_timeout",     timeout,     0);
    checkOutput("rst_busy",        busy,        0);
    @(posedge pll_clk);
    #2 reset_n_async = 1'b1;
    repeat (4) @(posedge pll_clk);

    // Single measurement; a second start while busy is ignored
    base = valid_seen;
    pulseStart();
    checkOutput("t1_busy", busy, 1);
    repeat (15) @(posedge pll_clk);
    pulseStart();
    waitValid(base + 1, 200, "t1_wait");
    checkOutput("t1_count",    count,      40);
    checkOutput("t1_in_range", in_range,   1);
    checkOutput("t1_locked",   pll_locked, 0);
    repeat (60) @(posedge pll_clk);
    #1;
    checkOutput("t1_single_valid", valid_seen, base + 1);
    checkOutput("t1_idle",         busy,       0);

    // Continuous mode: lock on the 4th in-range window, lost on a slow window
    applyReset();
    base = valid_seen;
    @(posedge pll_clk);
    #1 enable = 1'b1;
    waitValid(base + 3, 300, "t2_wait3");
    checkOutput("t2_locked_3", pll_locked, 0);
    waitValid(base + 4, 100, "t2_wait4");
    checkOutput("t2_locked_4", pll_locked, 1);
    checkOutput("t2_count_4",  count,      40);
    ext_period = 12;
    waitValid(base + 5, 100, "t2_wait5");
    checkOutput("t2_count_slow",    count,      48);
    checkOutput("t2_in_range_slow", in_range,   0);
    checkOutput("t2_locked_slow",   pll_locked, 0);
    ext_period = 10;
    waitValid(base + 9, 400, "t2_wait9");
    checkOutput("t2_relocked", pll_locked, 1);

    // Drop enable mid-window: abort, no result, lock cleared
    repeat (20) @(posedge pll_clk);
    #1;
    checkOutput("t6_busy_mid", busy, 1);
    enable = 1'b0;
    @(posedge pll_clk);
    #1;
    m_good = 0;
    m_lock = 1'b0;
    checkOutput("t6_abort_busy",   busy,       0);
    checkOutput("t6_abort_locked", pll_locked, 0);
    repeat (80) @(posedge pll_clk);
    #1;
    checkOutput("t6_abort_no_valid", valid_seen, base + 9);

    // Asynchronous reset in the middle of a locked measurement
    base = valid_seen;
    enable = 1'b1;
    waitValid(base + 4, 400, "t6_wait_lock");
    checkOutput("t6_locked_before_rst", pll_locked, 1);
    repeat (20) @(posedge pll_clk);
    #3;
    reset_n_async = 1'b0;
    enable        = 1'b0;
    modelClear();
    #1;
    checkOutput("t6_rst_count",       count,       0);
    checkOutput("t6_rst_count_valid", count_valid, 0);
    checkOutput("t6_rst_in_range",    in_range,    0);
    checkOutput("t6_rst_locked",      pll_locked,  0);
    checkOutput("t6_rst_overflow",    overflow,    0);
    checkOutput("t6_rst_timeout",     timeout,     0);
    checkOutput("t6_rst_busy",        busy,        0);
    repeat (2) @(posedge pll_clk);
    #2 reset_n_async = 1'b1;
    repeat (4) @(posedge pll_clk);

    // ext_clk stuck low: timeout after all-ones ARM cycles
    applyStimulus(0, 4, 38, 42);
    base = valid_seen;
    pulseStart();
    waitValid(base + 1, CNT_MAXV + 200, "t3_wait");
    checkOutput("t3_count",      count,    0);
    checkOutput("t3_timeout",    timeout,  1);
    checkOutput("t3_in_range",   in_range, 0);
    checkOutput("t3_overflow",   overflow, 0);
    checkOutput("t3_arm_cycles", valid_cyc - start_cyc, CNT_MAXV);

    // Window zero, saturation, exact saturation edge and range limits
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].period, vecs[i].win, vecs[i].mn, vecs[i].mx);
      base = valid_seen;
      pulseStart();
      waitValid(base + 1, 8000, "vec_wait");
      checkOutput($sformatf("vec%0d_count", i),    count,    vecs[i].exp_count);
      checkOutput($sformatf("vec%0d_in_range", i), in_range, vecs[i].exp_inr);
      checkOutput($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ovf);
      checkOutput($sformatf("vec%0d_timeout", i),  timeout,  0);
      repeat (3) @(posedge pll_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
